jt1943_rom_arbiter: RTL and testbench

//   Shares one SDRAM read port among SLOTS ROM request caches (jt1943_romrq style).

---
 rtl/jt1943_rom_arbiter.sv | 135 +++++++++++++
 tb/tb_jt1943_rom_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt1943_rom_arbiter.sv
// Round-robin arbiter sharing one SDRAM read port among SLOTS ROM request caches.
// Each grant issues one 32-bit word read and strobes the result back to the granted slot.
module jt1943_rom_arbiter #(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int WAITW = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cen,
  input  logic [SLOTS-1:0]    slot_req,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_we,
  output logic [31:0]         data_out,
  output logic [AW-1:0]       sdram_addr,
  output logic                sdram_rd,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [31:0]         sdram_din,
  output logic                busy,
  output logic                timeout_err
);

  localparam int GW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  state_t            state_r;
  logic [GW-1:0]     grant_r;
  logic [GW-1:0]     last_r;
  logic [WAITW-1:0]  timer_r;
  logic [GW-1:0]     pick_s;
  logic [GW-1:0]     idx_s;
  logic              found_s;
  logic [AW-1:0]     pick_addr_s;
  logic [AW-1:0]     addr_a [SLOTS];

  // Unpack the flat slot address bus into one word per slot
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      addr_a[i] = slot_addr[i*AW +: AW];
    end
  end

  // Round-robin pick: first requester scanning from last+1, wrapping modulo SLOTS
  always_comb begin
    pick_s      = last_r;
    found_s     = 1'b0;
    idx_s       = {GW{1'b0}};
    pick_addr_s = {AW{1'b0}};
    for (int i = 1; i <= SLOTS; i++) begin
      idx_s = GW'((int'(last_r) + i) % SLOTS);
      if (!found_s && slot_req[idx_s]) begin
        pick_s      = idx_s;
        pick_addr_s = addr_a[idx_s];
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Transaction FSM with registered SDRAM-side and data outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sdram_rd    <= 1'b0;
      data_out    <= 32'h0000_0000;
      sdram_addr  <= {AW{1'b0}};
      timeout_err <= 1'b0;
      grant_r     <= {GW{1'b0}};
      last_r      <= GW'(SLOTS - 1);
      timer_r     <= {WAITW{1'b0}};
    end else begin
      timeout_err <= 1'b0;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            grant_r    <= pick_s;
            last_r     <= pick_s;
            sdram_addr <= pick_addr_s;
            sdram_rd   <= 1'b1;
            state_r    <= ISSUE;
          end
        end
        ISSUE: begin
          // data_rdy is only meaningful once the controller has accepted the read
          if (sdram_ack) begin
            sdram_rd <= 1'b0;
            timer_r  <= {WAITW{1'b0}};
            if (data_rdy) begin
              data_out <= sdram_din;
              state_r  <= DELIVER;
            end else begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          timer_r <= timer_r + WAITW'(1);
          if (data_rdy) begin
            data_out <= sdram_din;
            state_r  <= DELIVER;
          end else if (&timer_r) begin
            timeout_err <= 1'b1;
            state_r     <= IDLE;
          end
        end
        DELIVER: begin
          if (cen) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Write strobe and busy decode straight from state so the strobe spans all of DELIVER
  always_comb begin
    slot_we = {SLOTS{1'b0}};
    if (state_r == DELIVER) begin
      slot_we[grant_r] = 1'b1;
    end else begin
      slot_we = {SLOTS{1'b0}};
    end
    busy = (state_r != IDLE);
  end

endmodule

// File: tb/tb_jt1943_rom_arbiter.sv
// Scoreboard bench for jt1943_rom_arbiter: stimulus pushes expected deliveries,
// a negedge monitor pops and compares them whenever a strobe meets cen.
module tb_jt1943_rom_arbiter;
  localparam int SLOTS = 4;
  localparam int AW    = 22;
  localparam int WAITW = 6;

  logic                clk = 1'b0;
  logic                rst, cen;
  logic [SLOTS-1:0]    slot_req;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS-1:0]    slot_we;
  logic [31:0]         data_out;
  logic [AW-1:0]       sdram_addr;
  logic                sdram_rd, sdram_ack, data_rdy, busy, timeout_err;
  logic [31:0]         sdram_din;

  jt1943_rom_arbiter #(.SLOTS(SLOTS), .AW(AW), .WAITW(WAITW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .slot_req(slot_req), .slot_addr(slot_addr),
    .slot_we(slot_we), .data_out(data_out), .sdram_addr(sdram_addr), .sdram_rd(sdram_rd),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .sdram_din(sdram_din), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            slot;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          tout_cnt = 0;
  int          ack_dly = 0, rdy_dly = 1;
  bit          rdy_en = 1'b1, use_ovr = 1'b0, cen_mode = 1'b0;
  logic        cen_val = 1'b1;
  logic [31:0] ovr_data = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] data_fn(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {10'd0, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // All stimulus advances through here so cen is driven from one place
  task automatic tick();
    @(posedge clk);
    #1;
    if (cen_mode) cen = (cyc % 4 == 0);
    else          cen = cen_val;
  endtask

  function automatic bit cond(input int which);
    case (which)
      0:       return busy && !sdram_rd && (slot_we == '0);
      1:       return slot_we != '0;
      2:       return sdram_rd;
      3:       return timeout_err;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      hit = cond(which);
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s wait expired after %0d cycles", name, budget);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s drain expired, %0d deliveries missing", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic set_req(input int slot, input logic [AW-1:0] addr);
    slot_req[slot] = 1'b1;
    slot_addr[slot*AW +: AW] = addr;
  endtask

  task automatic push(input int slot, input logic [AW-1:0] addr, input logic [31:0] data);
    exp_t e;
    e.slot = slot; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    slot_req = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // SDRAM controller model: ack after ack_dly cycles, data_rdy rdy_dly cycles after ack
  initial begin
    int ctl, cnt;
    ctl = 0; cnt = 0;
    sdram_ack = 1'b0; data_rdy = 1'b0; sdram_din = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      sdram_ack = 1'b0;
      data_rdy  = 1'b0;
      if (rst) begin
        ctl = 0;
      end else begin
        if (ctl == 2) begin
          if (!rdy_en) begin
            if (!busy) ctl = 0;
          end else begin
            cnt--;
            if (cnt <= 0) begin
              data_rdy  = 1'b1;
              sdram_din = use_ovr ? ovr_data : data_fn(sdram_addr);
              ctl = 0;
            end
          end
        end else if (ctl == 0 && sdram_rd) begin
          ctl = 1;
          cnt = ack_dly;
        end
        if (ctl == 1) begin
          if (cnt == 0) begin
            sdram_ack = 1'b1;
            if (rdy_en && rdy_dly == 0) begin
              data_rdy  = 1'b1;
              sdram_din = use_ovr ? ovr_data : data_fn(sdram_addr);
              ctl = 0;
            end else begin
              ctl = 2;
              cnt = rdy_dly;
            end
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on the strobe cycle that meets cen
  initial begin
    logic [SLOTS-1:0] p_we;
    logic             p_cen;
    logic [31:0]      p_data;
    exp_t             e;
    p_we = '0; p_cen = 1'b0; p_data = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_we = '0;
        p_cen = 1'b0;
      end else begin
        if (timeout_err) tout_cnt++;
        if (p_we != '0 && p_cen) begin
          chk("we_exit", slot_we, 0);
        end else if (p_we != '0 && slot_we != '0) begin
          chk("we_hold", slot_we, p_we);
          chk("data_stable", data_out, p_data);
        end
        if (slot_we != '0 && cen) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_we actual=%0h required=none", slot_we);
          end else begin
            e = sb.pop_front();
            chk("we_slot", slot_we, 64'(1) << e.slot);
            chk("addr", sdram_addr, e.addr);
            chk("data", data_out, e.data);
          end
        end
        p_we = slot_we; p_cen = cen; p_data = data_out;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int c0, c1;
    rst = 1'b1; cen = 1'b0; slot_req = '0; slot_addr = '0;
    repeat (3) tick();
    chk("rst_sdram_rd", sdram_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_slot_we", slot_we, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_sdram_addr", sdram_addr, 0);
    chk("rst_timeout", timeout_err, 0);
    rst = 1'b0;
    tick();

    // 1: single slot, slow controller, cen every 4th clk
    cen_mode = 1'b1; ack_dly = 2; rdy_dly = 3; use_ovr = 1'b1; ovr_data = 32'hDEAD_BEEF;
    push(2, 22'h01234, 32'hDEAD_BEEF);
    set_req(2, 22'h01234);
    wait_drain("t1", 200);
    slot_req = '0;
    tick();

    // 2: all slots request, grant order 0,1,2,3,0,1 from reset
    do_reset();
    cen_mode = 1'b0; cen_val = 1'b1; ack_dly = 1; rdy_dly = 1; use_ovr = 1'b0;
    set_req(0, 22'h0A000); set_req(1, 22'h0B111); set_req(2, 22'h0C222); set_req(3, 22'h0D333);
    push(0, 22'h0A000, data_fn(22'h0A000));
    push(1, 22'h0B111, data_fn(22'h0B111));
    push(2, 22'h0C222, data_fn(22'h0C222));
    push(3, 22'h0D333, data_fn(22'h0D333));
    push(0, 22'h0A000, data_fn(22'h0A000));
    push(1, 22'h0B111, data_fn(22'h0B111));
    wait_drain("t2", 300);
    slot_req = '0;
    tick();

    // 3: no data after ack, timeout after 64 WAIT cycles, then re-grant
    do_reset();
    ack_dly = 0; rdy_dly = 1; rdy_en = 1'b0; tout_cnt = 0;
    push(1, 22'h2ABCD, data_fn(22'h2ABCD));
    set_req(1, 22'h2ABCD);
    wait_for("t3_wait", 0, 20);
    c0 = cyc;
    wait_for("t3_timeout", 3, 200);
    c1 = cyc;
    rdy_en = 1'b1;
    chk("t3_timeout_cycles", c1 - c0, 64);
    wait_drain("t3", 50);
    slot_req = '0;
    tick();
    chk("t3_pulse_count", tout_cnt, 1);

    // 4: ack and data_rdy together skip WAIT
    ack_dly = 0; rdy_dly = 0; use_ovr = 1'b1; ovr_data = 32'h0055_AA33;
    push(3, 22'h3F0F0, 32'h0055_AA33);
    set_req(3, 22'h3F0F0);
    wait_for("t4_rd", 2, 20);
    c0 = cyc;
    wait_for("t4_we", 1, 20);
    c1 = cyc;
    chk("t4_skip_wait", c1 - c0, 1);
    wait_drain("t4", 20);
    slot_req = '0;
    tick();

    // 5a: slot_req drops during WAIT, read still delivered
    use_ovr = 1'b0; ack_dly = 0; rdy_dly = 6;
    push(0, 22'h00777, data_fn(22'h00777));
    set_req(0, 22'h00777);
    wait_for("t5_wait", 0, 20);
    slot_req = '0;
    wait_drain("t5a", 50);
    tick();

    // 5b: reset in WAIT drops the read
    rdy_en = 1'b0;
    set_req(2, 22'h15555);
    wait_for("t5b_wait", 0, 20);
    tick();
    chk("t5b_busy_before", busy, 1);
    rst = 1'b1; slot_req = '0;
    tick();
    chk("t5b_sdram_rd", sdram_rd, 0);
    chk("t5b_busy", busy, 0);
    chk("t5b_slot_we", slot_we, 0);
    chk("t5b_data_out", data_out, 0);
    rst = 1'b0; rdy_en = 1'b1;
    repeat (4) tick();

    // 6: cen low for 10 clk in DELIVER
    cen_val = 1'b0; ack_dly = 0; rdy_dly = 1;
    push(3, 22'h2468A, data_fn(22'h2468A));
    set_req(3, 22'h2468A);
    wait_for("t6_we", 1, 20);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("t6_held", slot_we, 4'b1000);
    end
    cen_val = 1'b1;
    tick();
    chk("t6_last", slot_we, 4'b1000);
    tick();
    chk("t6_exit_we", slot_we, 0);
    chk("t6_exit_busy", busy, 0);
    slot_req = '0;
    repeat (4) tick();
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
